// File: rtl/token_window_counter.sv
// token_window_counter: counts serial tokens over back-to-back WINDOW-cycle
// windows and hands each count to a consumer through a one-entry valid/ready slot.
module token_window_counter #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt_sat,
  output logic             drop
);

  localparam int IDX_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] MAX = '1;

  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_acc;
  logic             r_sat;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cnt_sat;
  logic             r_valid;
  logic             r_drop;

  logic             w_close;
  logic             w_ovf;
  logic [CNT_W-1:0] w_sum;
  logic             w_fsat;
  logic             w_accept;
  logic             w_load;

  always_comb begin
    w_close  = (r_idx == LAST);
    w_ovf    = a & (r_acc == MAX);
    w_sum    = w_ovf ? r_acc : r_acc + CNT_W'(a);
    w_fsat   = r_sat | w_ovf;
    w_accept = r_valid & cnt_ready;
    // A full slot that is not being drained this edge cannot take the result.
    w_load   = w_close & (~r_valid | w_accept);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_acc     <= '0;
      r_sat     <= 1'b0;
      r_cnt     <= '0;
      r_cnt_sat <= 1'b0;
      r_valid   <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_idx  <= w_close ? '0 : r_idx + IDX_W'(1);
      r_acc  <= w_close ? '0 : w_sum;
      r_sat  <= w_close ? 1'b0 : w_fsat;
      r_drop <= w_close & ~w_load;
      if (w_load) begin
        r_cnt     <= w_sum;
        r_cnt_sat <= w_fsat;
        r_valid   <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign cnt_valid = r_valid;
  assign cnt       = r_cnt;
  assign cnt_sat   = r_cnt_sat;
  assign drop      = r_drop;

endmodule

// File: tb/tb_token_window_counter.sv
// Bench for token_window_counter: directed windows, expected transfers
// and drops queued by the stimulus and matched by a negedge monitor.
module tb_token_window_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0;
  logic cnt_ready = 1'b0;

  logic       va, sa, da;
  logic [2:0] ca;
  logic       vb, sb, db;
  logic [1:0] cb;

  token_window_counter #(.WINDOW(4), .CNT_W(3)) dut_a (
    .clk(clk), .rst(rst), .a(a),
    .cnt_valid(va), .cnt_ready(cnt_ready),
    .cnt(ca), .cnt_sat(sa), .drop(da)
  );

  token_window_counter #(.WINDOW(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .a(a),
    .cnt_valid(vb), .cnt_ready(cnt_ready),
    .cnt(cb), .cnt_sat(sb), .drop(db)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int cnt;
    bit sat;
    bit is_drop;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   sel = 1'b0;

  function automatic logic [31:0] mk(input string s);
    logic [31:0] r;
    int k;
    r = '0;
    k = 0;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "1") begin
        r[k] = 1'b1;
        k++;
      end else if (s[i] == "0") begin
        k++;
      end
    end
    return r;
  endfunction

  task automatic push(input int c, input int n, input bit s, input bit d);
    exp_t e;
    e.cyc = c;
    e.cnt = n;
    e.sat = s;
    e.is_drop = d;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic observe(input int n, input bit s, input bit d);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s cyc=%0d got cnt=%0d sat=%0d want none",
               d ? "drop" : "xfer", cyc, n, s);
    end else begin
      e = q.pop_front();
      if (e.cyc != cyc || e.cnt != n || e.sat != s || e.is_drop != d) begin
        errors++;
        $display("FAIL event got cyc=%0d cnt=%0d sat=%0d drop=%0d want cyc=%0d cnt=%0d sat=%0d drop=%0d",
                 cyc, n, s, d, e.cyc, e.cnt, e.sat, e.is_drop);
      end
    end
  endtask

  always @(negedge clk) begin
    logic v, s, d;
    int   n;
    v = sel ? vb : va;
    s = sel ? sb : sa;
    d = sel ? db : da;
    n = sel ? int'(cb) : int'(ca);
    if (d === 1'b1)
      observe(n, s, 1'b1);
    if (v === 1'b1 && cnt_ready === 1'b1)
      observe(n, s, 1'b0);
  end

  task automatic step(input logic av, input logic rv, input logic rs);
    a = av;
    cnt_ready = rv;
    rst = rs;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input logic [31:0] av, input logic [31:0] rv,
                     input logic [31:0] rs, input int upto);
    while (cyc < upto)
      step(av[cyc], rv[cyc], rs[cyc]);
  endtask

  task automatic do_reset(input bit s);
    sel = s;
    rst = 1'b1;
    a = 1'b0;
    cnt_ready = 1'b0;
    cyc = -100;
    repeat (2) @(posedge clk);
    #1;
    chk(s ? "rst_valid_b" : "rst_valid", s ? int'(vb) : int'(va), 0);
    chk("rst_cnt", s ? int'(cb) : int'(ca), 0);
    chk("rst_sat", s ? int'(sb) : int'(sa), 0);
    chk("rst_drop", s ? int'(db) : int'(da), 0);
    rst = 1'b0;
    cyc = 0;
  endtask

  logic [31:0] nors;

  initial begin
    nors = '0;

    // Three windows with ready high: last-cycle token and zero count.
    do_reset(1'b0);
    push(4, 3, 1'b0, 1'b0);
    push(8, 1, 1'b0, 1'b0);
    push(12, 0, 1'b0, 1'b0);
    run(mk("1101 0001 0000 0"), mk("1111 1111 1111 1"), nors, 5);
    chk("valid_after_xfer", int'(va), 0);
    run(mk("1101 0001 0000 0"), mk("1111 1111 1111 1"), nors, 13);

    // Saturation on a 2-bit counter, then the flag clears.
    do_reset(1'b1);
    push(4, 3, 1'b1, 1'b0);
    push(8, 2, 1'b0, 1'b0);
    run(mk("1111 0110 0"), mk("1111 1111 1"), nors, 9);
    sel = 1'b0;

    // Consumer stalled: held result, drop pulse, late accept.
    do_reset(1'b0);
    push(8, 4, 1'b0, 1'b1);
    push(10, 4, 1'b0, 1'b0);
    run(mk("1111 1111 1111"), mk("0000 0000 0010"), nors, 4);
    chk("stall_valid", int'(va), 1);
    chk("stall_cnt", int'(ca), 4);
    run(mk("1111 1111 1111"), mk("0000 0000 0010"), nors, 11);
    chk("valid_after_late_accept", int'(va), 0);
    run(mk("1111 1111 1111"), mk("0000 0000 0010"), nors, 12);
    chk("next_window_valid", int'(va), 1);
    chk("next_window_cnt", int'(ca), 4);

    // Accept and load on the same edge.
    do_reset(1'b0);
    push(7, 1, 1'b0, 1'b0);
    run(mk("1000 1100 0"), mk("0000 0001 0"), nors, 8);
    chk("same_edge_valid", int'(va), 1);
    chk("same_edge_cnt", int'(ca), 2);
    chk("same_edge_drop", int'(da), 0);
    run(mk("1000 1100 0"), mk("0000 0001 0"), nors, 9);

    // Reset mid-window restarts the window.
    do_reset(1'b0);
    push(7, 3, 1'b0, 1'b0);
    run(mk("111 0111 0"), mk("111 1111 1"), mk("001 0000 0"), 3);
    chk("midrst_valid", int'(va), 0);
    chk("midrst_drop", int'(da), 0);
    run(mk("111 0111 0"), mk("111 1111 1"), mk("001 0000 0"), 8);

    // Reset with a pending result discards it.
    do_reset(1'b0);
    run(mk("1111 0 0 0000"), mk("0000 0 0 1111"), mk("0000 0 1 0000"), 5);
    chk("pend_valid", int'(va), 1);
    chk("pend_cnt", int'(ca), 4);
    run(mk("1111 0 0 0000"), mk("0000 0 0 1111"), mk("0000 0 1 0000"), 7);
    chk("pend_lost_valid", int'(va), 0);
    chk("pend_lost_drop", int'(da), 0);
    run(mk("1111 0 0 0000"), mk("0000 0 0 1111"), mk("0000 0 1 0000"), 10);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover_events got=%0d want=0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
